// File: rtl/bram_stream_reader.sv
// Read-side master for a single-port BRAM: streams `length` words from `start_addr`
// onto a valid/ready interface through a 2-entry skid FIFO with full backpressure.
module bram_stream_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic                  bram_we,
  output logic [DATA_WIDTH-1:0] bram_din,
  input  logic [DATA_WIDTH-1:0] bram_dout,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [ADDR_WIDTH:0]     issue_cnt_q, issue_cnt_d;
  logic [ADDR_WIDTH:0]     beat_cnt_q, beat_cnt_d;
  logic                    inflight_q, inflight_d;
  logic [1:0]              fifo_count_q, fifo_count_d;
  logic [DATA_WIDTH-1:0]   head_q, head_d;
  logic [DATA_WIDTH-1:0]   tail_q, tail_d;

  logic                    pop;
  logic                    push;
  logic                    issue;
  logic [1:0]              occ;
  logic [2:0]              pending;

  assign busy      = (state_q == RUN) || (state_q == DONE);
  assign done      = (state_q == DONE);
  assign bram_addr = addr_q;
  assign bram_we   = 1'b0;
  assign bram_din  = '0;
  assign m_valid   = (fifo_count_q != 2'd0);
  assign m_data    = head_q;
  assign m_last    = m_valid && (beat_cnt_q == CNT_ONE);

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    issue_cnt_d  = issue_cnt_q;
    beat_cnt_d   = beat_cnt_q;
    head_d       = head_q;
    tail_d       = tail_q;

    pop  = m_valid && m_ready;
    push = inflight_q;

    // Reads in flight plus words held must never exceed the FIFO depth.
    pending = {1'b0, fifo_count_q} + {2'b00, inflight_q};
    issue   = (state_q == RUN) && (issue_cnt_q != '0) &&
              ((pending < 3'd2) || ((pending == 3'd2) && pop));

    occ = fifo_count_q - {1'b0, pop};
    if (pop && (fifo_count_q == 2'd2)) head_d = tail_q;
    if (push) begin
      if (occ == 2'd0) head_d = bram_dout;
      else             tail_d = bram_dout;
    end
    fifo_count_d = occ + {1'b0, push};

    if (pop) beat_cnt_d = beat_cnt_q - CNT_ONE;

    inflight_d = issue;
    if (issue) begin
      addr_d      = addr_q + ADDR_ONE;
      issue_cnt_d = issue_cnt_q - CNT_ONE;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          if (length != '0) begin
            state_d     = RUN;
            addr_d      = start_addr;
            issue_cnt_d = length;
            beat_cnt_d  = length;
          end else begin
            state_d = DONE;
          end
        end
      end
      RUN:     if (pop && (beat_cnt_q == CNT_ONE)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      issue_cnt_q  <= '0;
      beat_cnt_q   <= '0;
      inflight_q   <= 1'b0;
      fifo_count_q <= 2'd0;
      head_q       <= '0;
      tail_q       <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      issue_cnt_q  <= issue_cnt_d;
      beat_cnt_q   <= beat_cnt_d;
      inflight_q   <= inflight_d;
      fifo_count_q <= fifo_count_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
    end
  end

endmodule

// File: tb/tb_bram_stream_reader.sv
// Randomized bench for bram_stream_reader: behavioural BRAM plus a queue-based
// expectation of the word sequence, checked beat by beat under backpressure.
module tb_bram_stream_reader;

  localparam int DW    = 32;
  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] start_addr;
  logic [AW:0]   length;
  logic          busy, done;
  logic [AW-1:0] bram_addr;
  logic          bram_we;
  logic [DW-1:0] bram_din;
  logic [DW-1:0] bram_dout;
  logic          m_valid, m_ready, m_last;
  logic [DW-1:0] m_data;

  logic [DW-1:0] mem [DEPTH];
  int            n_vec = 0;
  int            n_err = 0;
  bit            pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  bram_stream_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
    .length(length), .busy(busy), .done(done), .bram_addr(bram_addr),
    .bram_we(bram_we), .bram_din(bram_din), .bram_dout(bram_dout),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
  );

  always #5 clk = ~clk;

  // Single-port BRAM read port with one cycle of registered latency.
  always @(posedge clk) bram_dout <= mem[bram_addr];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic xfer(input int sa, input int len, input int rmode, input bit dbl);
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] pdata;
    logic          plast;
    bit            stall;
    int            idx, done_t, last_hs, first_v, limit;
    for (int i = 0; i < len; i++) exp_q.push_back(mem[(sa + i) % DEPTH]);
    idx = 0; done_t = -1; last_hs = -1; first_v = -1; stall = 1'b0;
    pdata = '0; plast = 1'b0;
    limit = 4 * len + 20;

    @(negedge clk);
    check("idle_busy", busy, 0);
    start      = 1'b1;
    start_addr = AW'(sa % DEPTH);
    length     = (AW+1)'(len);
    m_ready    = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check("busy_on", busy, 1);
    if (len > 0) check("first_addr", bram_addr, sa % DEPTH);

    for (int t = 0; t < limit && done_t < 0; t++) begin
      if (t > 0) @(negedge clk);
      start = dbl && (t == 3);
      case (rmode)
        0:       m_ready = 1'b1;
        1:       m_ready = 1'($urandom_range(0, 1));
        default: m_ready = pat[t % 6];
      endcase
      if (stall) begin
        check("stall_valid", m_valid, 1);
        check("stall_data", m_data, pdata);
        check("stall_last", m_last, plast);
      end
      check("fifo_le2", dut.fifo_count_q <= 2'd2, 1);
      if (m_valid && first_v < 0) first_v = t;
      if (done) done_t = t;
      if (m_valid && m_ready) begin
        if (idx < len) begin
          check("data", m_data, exp_q[idx]);
          check("last", m_last, idx == len - 1);
        end else begin
          check("extra_beat", 1, 0);
        end
        idx++;
        last_hs = t;
      end
      stall = m_valid && !m_ready;
      pdata = m_data;
      plast = m_last;
    end
    start = 1'b0;

    if (done_t < 0) begin
      check("timeout", 0, 1);
    end else begin
      check("beats", idx, len);
      check("done_time", done_t, (len == 0) ? 0 : last_hs + 1);
      if (rmode == 0 && len > 0) begin
        check("first_valid", first_v, 2);
        check("done_stream", done_t, len + 2);
      end
    end

    @(negedge clk);
    check("done_pulse", done, 0);
    check("busy_off", busy, 0);
    check("valid_off", m_valid, 0);
    if (len > 0) check("end_addr", bram_addr, (sa + len) % DEPTH);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("quiet_done", done, 0);
      check("quiet_valid", m_valid, 0);
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
  endtask

  task automatic reset_mid();
    mem[3] = 32'hAABBCCDD; mem[4] = 32'h11223344; mem[5] = 32'hDEADBEEF;
    @(negedge clk);
    start = 1'b1; start_addr = AW'(3); length = (AW+1)'(5); m_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_pre_valid", m_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_valid", m_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_addr", bram_addr, 0);
    check("rst_data", m_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("post_rst_valid", m_valid, 0);
      check("post_rst_done", done, 0);
      check("post_rst_busy", busy, 0);
    end
    xfer(3, 1, 0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; m_ready = 1'b0;
    start_addr = '0; length = '0;
    fill_random();
    repeat (3) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_valid", m_valid, 0);
    check("reset_last", m_last, 0);
    check("reset_data", m_data, 0);
    check("reset_addr", bram_addr, 0);
    check("bram_we", bram_we, 0);
    check("bram_din", bram_din, 0);
    rst_n = 1'b1;

    mem[3] = 32'hAABBCCDD; mem[4] = 32'h11223344; mem[5] = 32'hDEADBEEF;
    xfer(3, 3, 0, 1'b0);
    xfer(3, 3, 2, 1'b0);

    mem[1022] = 32'hA0; mem[1023] = 32'hA1; mem[0] = 32'hA2; mem[1] = 32'hA3;
    xfer(1022, 4, 0, 1'b0);

    xfer(5, 0, 0, 1'b0);
    xfer($urandom_range(0, DEPTH - 1), 8, 0, 1'b1);

    for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i);
    xfer(0, DEPTH, 0, 1'b0);

    reset_mid();

    for (int r = 0; r < 12; r++) begin
      fill_random();
      xfer($urandom_range(0, DEPTH - 1), $urandom_range(0, 40), $urandom_range(0, 2), 1'b0);
    end
    fill_random();
    xfer(700, DEPTH, 1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bram_stream_reader.md
Name: bram_stream_reader

Overview:
- Read-side master for the single-port `bram` block (`clk`, `we`, `addr`, `din`, `dout`; 1-cycle registered read latency).
- On a `start` command it reads `length` consecutive words beginning at `start_addr`.
- The words are emitted on a valid/ready stream with full backpressure support, and `m_last` marks the final beat.
- It sits between a BRAM instance and downstream consumers such as DMA and packetisers, replacing hand-driven address sequencing.

Parameters:
- `DATA_WIDTH`, 32, BRAM word width.
- `ADDR_WIDTH`, 10, BRAM address width; depth is 2^ADDR_WIDTH.

Ports:
- `clk` input 1: single clock; all state updates on rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `start` input 1: command strobe; sampled only in IDLE.
- `start_addr` input ADDR_WIDTH: first word address; sampled with `start`.
- `length` input ADDR_WIDTH+1: word count, 0 to 2^ADDR_WIDTH; sampled with `start`.
- `busy` output 1: high from the cycle after an accepted `start` until `done`.
- `done` output 1: one-cycle pulse at transfer completion.
- `bram_addr` output ADDR_WIDTH: address to BRAM `addr`.
- `bram_we` output 1: to BRAM `we`; constant 0.
- `bram_din` output DATA_WIDTH: to BRAM `din`; constant 0.
- `bram_dout` input DATA_WIDTH: from BRAM `dout`.
- `m_valid` output 1: stream data valid.
- `m_ready` input 1: stream sink ready.
- `m_data` output DATA_WIDTH: stream word.
- `m_last` output 1: high with the final beat of a transfer.

Behaviour:
- **Reset** (`rst_n` low, asynchronous):
  - state IDLE; `busy`=0, `done`=0, `m_valid`=0, `m_last`=0, `m_data`=0, `bram_addr`=0;
  - FIFO emptied, in-flight flag cleared, remaining/beat counters cleared.
  - Reset mid-transfer abandons the transfer: no `done`, no further beats.
- **States:** IDLE, RUN, DONE.
  - IDLE -> RUN: `start`=1 and `length`!=0. Load `bram_addr`<=`start_addr`, `issue_cnt`<=`length`, `beat_cnt`<=`length`.
  - IDLE -> DONE: `start`=1 and `length`=0. No BRAM reads, no beats.
  - RUN -> DONE: on handshake (`m_valid` & `m_ready`) of the beat where `beat_cnt`==1.
  - DONE -> IDLE: unconditionally after one cycle; `done`=1 only in DONE.
  - `start` in RUN or DONE is ignored.
- **`busy`:** 1 in RUN and DONE.
- **Read issue:**
  - `bram_addr` is a register; BRAM samples it every edge.
  - A cycle "issues" when state=RUN, `issue_cnt`>0, and one of:
    - (`fifo_count` + `inflight`) < 2; or
    - (`fifo_count` + `inflight`) == 2 and a stream pop occurs this cycle.
  - On issue, at the edge: `bram_addr` += 1 (wraps modulo 2^ADDR_WIDTH, e.g. 1023 -> 0), `issue_cnt` -= 1, `inflight`<=1.
  - Otherwise `inflight`<=0 and `bram_addr` holds.
- **Capture:** when `inflight`=1, `bram_dout` is valid in the following cycle and is pushed into the output FIFO at the end of that cycle.
- **Output FIFO:**
  - 2 entries; head drives `m_data`; `m_valid` = FIFO non-empty.
  - Push and pop in the same cycle are both honoured.
  - Overflow is impossible by the issue rule; the bench asserts `fifo_count` <= 2.
- **`m_last`:** `m_valid` & (`beat_cnt`==1). `beat_cnt` decrements on each handshake.
- **Stream rules:**
  - `m_data` and `m_last` hold stable while `m_valid`=1 and `m_ready`=0.
  - `m_valid` never drops without a handshake.
- **Latency:**
  - `start` sampled at edge E0: first address presented during cycle E0..E1, BRAM reads at E1, FIFO push at E2, `m_valid`=1 after E2.
  - With `m_ready` held 1: one beat per cycle, no bubbles.
  - Final handshake at edge Ef: `done`=1 during cycle Ef..Ef+1; `busy` drops after Ef+1.
- **Arithmetic:** `length` = 2^ADDR_WIDTH (1024) reads the whole memory once, with address wrap when `start_addr`!=0.

Test Plan:
- **Basic read:** preload BRAM 3/4/5 = AABBCCDD/11223344/DEADBEEF; `start_addr`=3, `length`=3, `m_ready`=1 -> beats AABBCCDD, 11223344, DEADBEEF on consecutive cycles; first `m_valid` 2 cycles after `start`; `m_last` on 3rd beat only; `done` pulse the next cycle.
- **Backpressure:** same data, `m_ready` toggling 1,0,0,1,0,1 -> identical ordered data, no loss or duplication; `m_data` stable while stalled; `fifo_count` never > 2.
- **Wrap-around:** preload 1022=A0, 1023=A1, 0=A2, 1=A3; `start_addr`=1022, `length`=4 -> A0, A1, A2, A3; `bram_addr` sequence 1022, 1023, 0, 1.
- **Zero length and ignored start:** `length`=0 -> `done` pulse one cycle later, `m_valid` never 1. A second `start` during a length-8 run -> exactly 8 beats, single `done`.
- **Full-depth:** `length`=1024, `start_addr`=0, memory[i]=i, `m_ready`=1 -> 1024 beats of 0..1023 in 1024 consecutive cycles, `m_last` on value 1023.
- **Reset mid-transfer:** assert `rst_n`=0 asynchronously (not on an edge) during beat 2 of 5 -> `m_valid`, `busy`, `done`, `bram_addr` go 0 immediately. After release, a new `start_addr`=3, `length`=1 returns AABBCCDD correctly.
